// File: rtl/arc_sine_seq.sv
// arc_sine_seq: inverse of the 8-bit angle-code sine encoding.
// The input x = +/-valueIn/10000 is mapped to the angle code k (angle = k*2*pi/256)
// whose sine is nearest to x, limited to [-pi/2, +pi/2]. The block also gives |angle|
// in radians as six BCD digits for the seven-segment path.
// The code is found with a 7-step binary search over a quarter-wave sine table and a
// single rounding step. The radian product is then converted with shift-add-3.
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// S_IDLE    | wait for start; reject out-of-range input straight to S_DONE
// S_SEARCH  | 7 cycles, decide one bit of k per cycle (largest k, S[k] <= x)
// S_ROUND   | move k up by one if S[k+1] is strictly closer to x; form k*RAD_MULT
// S_CONVERT | 18 cycles of double-dabble, one binary bit per cycle
// S_DONE    | publish results, pulse done, return to S_IDLE
module arc_sine_seq #(
    parameter int VAL_W       = 14,
    parameter int TABLE_SCALE = 10000,
    parameter int RAD_MULT    = 2454
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] valueIn,
    input  logic             signIn,
    output logic             busy,
    output logic             done,
    output logic [7:0]       angleOut,
    output logic [23:0]      hexOutput,
    output logic             negLedOut,
    output logic             rangeErr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_ROUND,
        S_CONVERT,
        S_DONE
    } state_t;

    localparam logic [VAL_W-1:0] LP_FULL = VAL_W'(TABLE_SCALE);
    localparam logic [17:0]      LP_RAD  = 18'(RAD_MULT);

    state_t             r_state;
    logic [VAL_W-1:0]   r_x;
    logic               r_sign;
    logic [6:0]         r_k;
    logic [2:0]         r_bit;
    logic [4:0]         r_cnt;
    logic [17:0]        r_bin;
    logic [23:0]        r_bcd;

    logic [6:0]         w_trial;
    logic [VAL_W-1:0]   w_s_trial;
    logic [VAL_W-1:0]   w_s_k;
    logic [VAL_W-1:0]   w_s_k1;
    logic               w_trial_ok;
    logic [VAL_W:0]     w_diff_up;
    logic [VAL_W:0]     w_diff_dn;
    logic [6:0]         w_k_rnd;
    logic [17:0]        w_prod;
    logic [23:0]        w_bcd_adj;

    // Quarter-wave table: round(10000*sin(2*pi*k/256)). Indices past 64 return full scale.
    // The search and round steps never use them.
    function automatic logic [VAL_W-1:0] sine_lut(input logic [6:0] idx);
        int v;
        case (idx)
            7'd0:  v = 0;    7'd1:  v = 245;  7'd2:  v = 491;  7'd3:  v = 736;
            7'd4:  v = 980;  7'd5:  v = 1224; 7'd6:  v = 1467; 7'd7:  v = 1710;
            7'd8:  v = 1951; 7'd9:  v = 2191; 7'd10: v = 2430; 7'd11: v = 2667;
            7'd12: v = 2903; 7'd13: v = 3137; 7'd14: v = 3369; 7'd15: v = 3599;
            7'd16: v = 3827; 7'd17: v = 4052; 7'd18: v = 4276; 7'd19: v = 4496;
            7'd20: v = 4714; 7'd21: v = 4929; 7'd22: v = 5141; 7'd23: v = 5350;
            7'd24: v = 5556; 7'd25: v = 5758; 7'd26: v = 5957; 7'd27: v = 6152;
            7'd28: v = 6344; 7'd29: v = 6532; 7'd30: v = 6716; 7'd31: v = 6895;
            7'd32: v = 7071; 7'd33: v = 7242; 7'd34: v = 7410; 7'd35: v = 7572;
            7'd36: v = 7730; 7'd37: v = 7883; 7'd38: v = 8032; 7'd39: v = 8176;
            7'd40: v = 8315; 7'd41: v = 8449; 7'd42: v = 8577; 7'd43: v = 8701;
            7'd44: v = 8819; 7'd45: v = 8932; 7'd46: v = 9040; 7'd47: v = 9142;
            7'd48: v = 9239; 7'd49: v = 9330; 7'd50: v = 9415; 7'd51: v = 9495;
            7'd52: v = 9569; 7'd53: v = 9638; 7'd54: v = 9700; 7'd55: v = 9757;
            7'd56: v = 9808; 7'd57: v = 9853; 7'd58: v = 9892; 7'd59: v = 9925;
            7'd60: v = 9952; 7'd61: v = 9973; 7'd62: v = 9988; 7'd63: v = 9997;
            default: v = TABLE_SCALE;
        endcase
        return VAL_W'(v);
    endfunction

    // Search trial, rounding decision, and radian product. The differences are taken one
    // bit wider than the input, so they cannot wrap below zero.
    always_comb begin
        w_trial    = r_k | (7'd1 << r_bit);
        w_s_trial  = sine_lut(w_trial);
        w_s_k      = sine_lut(r_k);
        w_s_k1     = sine_lut(r_k + 7'd1);
        w_trial_ok = (w_trial <= 7'd64) && (w_s_trial <= r_x);
        w_diff_up  = {1'b0, w_s_k1} - {1'b0, r_x};
        w_diff_dn  = {1'b0, r_x} - {1'b0, w_s_k};
        w_k_rnd    = ((r_k < 7'd64) && (w_diff_up < w_diff_dn)) ? r_k + 7'd1 : r_k;
        w_prod     = {11'd0, w_k_rnd} * LP_RAD;
    end

    // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 6; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_sign    <= 1'b0;
            r_k       <= '0;
            r_bit     <= '0;
            r_cnt     <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            angleOut  <= '0;
            hexOutput <= '0;
            negLedOut <= 1'b0;
            rangeErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (valueIn > LP_FULL) begin
                            rangeErr  <= 1'b1;
                            angleOut  <= '0;
                            hexOutput <= '0;
                            negLedOut <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_x      <= valueIn;
                            r_sign   <= signIn;
                            r_k      <= '0;
                            r_bit    <= 3'd6;
                            rangeErr <= 1'b0;
                            busy     <= 1'b1;
                            r_state  <= S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    if (w_trial_ok) begin
                        r_k <= w_trial;
                    end
                    if (r_bit == 3'd0) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_bit <= r_bit - 3'd1;
                    end
                end
                S_ROUND: begin
                    r_k     <= w_k_rnd;
                    r_bin   <= w_prod;
                    r_bcd   <= '0;
                    r_cnt   <= 5'd17;
                    r_state <= S_CONVERT;
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    // The range-error path has already zeroed the result outputs.
                    if (!rangeErr) begin
                        angleOut  <= r_sign ? (8'd0 - {1'b0, r_k}) : {1'b0, r_k};
                        negLedOut <= r_sign & (r_k != 7'd0);
                        hexOutput <= r_bcd;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
